// File: rtl/router_pkg.sv
// Shared definitions for the router output-channel sink: header layout,
// FSM state encoding and the beat format carried through the skid buffer.
package router_pkg;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_W  = 2;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;
  localparam int MAX_LEN = 63;

  // Reads still owed for one packet: up to MAX_LEN payload bytes plus parity.
  localparam int ISSUE_W = $clog2(MAX_LEN + 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_PARITY,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

endpackage

// File: rtl/router_skid_buf.sv
// One-entry holding register between the FIFO read path and the byte stream.
// A beat arriving while the holder is empty is presented straight through.
module router_skid_buf
  import router_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  flush,
  input  logic  in_valid,
  input  beat_t in_beat,
  output logic  full,
  output logic  hold_next,
  output logic  out_valid,
  output beat_t out_beat,
  input  logic  out_ready
);

  beat_t held;

  // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    out_valid = (full || in_valid) && !flush;
    out_beat  = '0;
    if (out_valid) begin
      out_beat = full ? held : in_beat;
    end
    hold_next = out_valid && !out_ready;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else begin
      full <= hold_next;
    end
  end

  // NOTE: the data holder is not reset; 'full' alone says whether its contents mean anything.
  always_ff @(posedge clk) begin
    if (hold_next) begin
      held <= out_beat;
    end
  end

endmodule

// File: rtl/router_port_sink.sv
// Sink for one router output channel: drains the channel FIFO, reassembles
// header/payload/parity, forwards payload bytes and keeps packet/error statistics.
module router_port_sink
  import router_pkg::*;
#(
  parameter int unsigned PORT_ID = 0,
  parameter int unsigned TIMEOUT = 32,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             vld_out,
  input  logic [7:0]       dout,
  output logic             rd_en,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             byte_sop,
  output logic             byte_eop,
  input  logic             out_ready,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             parity_err,
  output logic             addr_err,
  output logic             trunc_err,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int                TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PORT_ADDR = ADDR_W'(PORT_ID);

  state_t state;
  state_t state_next;

  logic               rd_pend;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   remaining;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         parity_acc;
  logic               parity_bad;
  logic               trunc_q;
  logic [ISSUE_W-1:0] issue_left;
  logic [TMO_W-1:0]   tmo_cnt;

  logic  tmo_active;
  logic  tmo_fire;
  logic  hdr_cap;
  logic  pay_cap;
  logic  par_cap;
  logic  finish;
  logic  any_err;
  logic  skid_full;
  logic  skid_hold;
  logic  skid_out_valid;
  beat_t skid_in;
  beat_t skid_out;

  // Event decode: rd_pend means the byte read last cycle is on dout now.
  assign tmo_active = (state == ST_PAYLOAD) || (state == ST_PARITY);
  assign tmo_fire   = tmo_active && !vld_out && (tmo_cnt == TMO_LAST);
  assign hdr_cap    = rd_pend && (state == ST_IDLE);
  assign pay_cap    = rd_pend && (state == ST_PAYLOAD) && !tmo_fire;
  assign par_cap    = rd_pend && (state == ST_PARITY) && !tmo_fire;
  assign finish     = (state == ST_DONE) && !skid_full;
  assign any_err    = parity_bad || trunc_q || (addr_q != PORT_ADDR);
  assign skid_in    = '{data: dout,
                        sop:  (remaining == len_q),
                        eop:  (remaining == LEN_W'(1))};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (hdr_cap) begin
          state_next = (dout[LEN_MSB:LEN_LSB] != '0) ? ST_PAYLOAD : ST_PARITY;
        end
      end
      ST_PAYLOAD: begin
        if (tmo_fire) begin
          state_next = ST_DONE;
        end else if (pay_cap && (remaining == LEN_W'(1))) begin
          state_next = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (tmo_fire || par_cap) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!skid_full) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The header read must land before the length is known; after that the
  // per-packet read budget keeps the next packet's header in the FIFO.
  always_comb begin
    rd_en = 1'b0;
    if (!rst && vld_out && !skid_hold) begin
      case (state)
        ST_IDLE:               rd_en = !rd_pend;
        ST_PAYLOAD, ST_PARITY: rd_en = (issue_left != '0);
        default:               rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend    <= 1'b0;
      len_q      <= '0;
      remaining  <= '0;
      addr_q     <= '0;
      parity_acc <= '0;
      parity_bad <= 1'b0;
      trunc_q    <= 1'b0;
      issue_left <= '0;
      tmo_cnt    <= '0;
    end else begin
      rd_pend <= rd_en;

      if (hdr_cap) begin
        len_q      <= dout[LEN_MSB:LEN_LSB];
        remaining  <= dout[LEN_MSB:LEN_LSB];
        addr_q     <= dout[ADDR_W-1:0];
        parity_acc <= dout;
        issue_left <= ISSUE_W'(dout[LEN_MSB:LEN_LSB]) + ISSUE_W'(1);
        parity_bad <= 1'b0;
        trunc_q    <= 1'b0;
      end else if (rd_en && (state != ST_IDLE)) begin
        issue_left <= issue_left - 1'b1;
      end

      if (pay_cap) begin
        parity_acc <= parity_acc ^ dout;
        remaining  <= remaining - 1'b1;
      end

      if (par_cap) begin
        parity_bad <= (dout != parity_acc);
      end

      // A truncated packet never saw its parity byte, so no parity verdict.
      if (tmo_fire) begin
        trunc_q    <= 1'b1;
        parity_bad <= 1'b0;
      end

      if (tmo_active && !vld_out && !tmo_fire) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_done   <= 1'b0;
      pkt_len    <= '0;
      parity_err <= 1'b0;
      addr_err   <= 1'b0;
      trunc_err  <= 1'b0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      pkt_done <= finish;
      if (finish) begin
        pkt_len    <= len_q;
        parity_err <= parity_bad;
        addr_err   <= (addr_q != PORT_ADDR);
        trunc_err  <= trunc_q;
        if (pkt_count != '1) begin
          pkt_count <= pkt_count + 1'b1;
        end
        if (any_err && (err_count != '1)) begin
          err_count <= err_count + 1'b1;
        end
      end
    end
  end

  router_skid_buf u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (tmo_fire),
    .in_valid  (pay_cap),
    .in_beat   (skid_in),
    .full      (skid_full),
    .hold_next (skid_hold),
    .out_valid (skid_out_valid),
    .out_beat  (skid_out),
    .out_ready (out_ready)
  );

  assign byte_out   = skid_out.data;
  assign byte_valid = skid_out_valid;
  assign byte_sop   = skid_out.sop;
  assign byte_eop   = skid_out.eop;

endmodule
